// File: rtl/mmcm_phaseshift_mc.sv
// Multi-channel MMCM dynamic phase-shift controller.
// Each channel walks its MMCM phase toward a latched, clamped signed target one
// PSEN/PSDONE handshake at a time, with a per-step PSDONE timeout.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset (shared with the external MMCMs)
//   target      packed signed target per channel, [i*PHASE_WIDTH +: PHASE_WIDTH]
//   configure   one-cycle per-channel request to latch target
//   configured  channel idle and phase equals latched target
//   err         sticky per-channel PSDONE timeout flag
//   phase       packed signed current applied phase per channel
//   ps_en       one-cycle MMCM PSEN pulse per channel
//   ps_inc_dec  MMCM PSINCDEC per channel (1 = increment)
//   ps_done     MMCM PSDONE per channel
module mmcm_phaseshift_mc #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned MAX_PHASE   = 280,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CH*PHASE_WIDTH-1:0]   target,
    input  logic [N_CH-1:0]               configure,
    output logic [N_CH-1:0]               configured,
    output logic [N_CH-1:0]               err,
    output logic [N_CH*PHASE_WIDTH-1:0]   phase,
    output logic [N_CH-1:0]               ps_en,
    output logic [N_CH-1:0]               ps_inc_dec,
    input  logic [N_CH-1:0]               ps_done
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic signed [PHASE_WIDTH-1:0] MAX_S = PHASE_WIDTH'(MAX_PHASE);
    localparam logic signed [PHASE_WIDTH-1:0] MIN_S = -MAX_S;
    localparam logic signed [PHASE_WIDTH-1:0] ONE_S = PHASE_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        state_t                        state_q, state_d;
        logic signed [PHASE_WIDTH-1:0] phase_q, phase_d;
        logic signed [PHASE_WIDTH-1:0] tgt_q, tgt_d;
        logic signed [PHASE_WIDTH-1:0] tgt_in, tgt_clamped;
        logic [CNT_W-1:0]              cnt_q, cnt_d;
        logic                          en_q, en_d;
        logic                          dir_q, dir_d;
        logic                          err_q, err_d;
        logic                          cfg_q, cfg_d;

        assign tgt_in = $signed(target[i*PHASE_WIDTH +: PHASE_WIDTH]);

        // Signed clamp of the requested target to the aliasing-safe range
        always_comb begin
            tgt_clamped = tgt_in;
            if (tgt_in > MAX_S) begin
                tgt_clamped = MAX_S;
            end else if (tgt_in < MIN_S) begin
                tgt_clamped = MIN_S;
            end
        end

        // Next-state and next-output logic
        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            tgt_d   = tgt_q;
            cnt_d   = cnt_q;
            en_d    = 1'b0;
            dir_d   = dir_q;
            err_d   = err_q;

            // Retarget takes effect at once; an in-flight step keeps its direction
            if (configure[i]) begin
                tgt_d = tgt_clamped;
                err_d = 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (configure[i] && (tgt_clamped != phase_q)) begin
                        state_d = S_STEP;
                        en_d    = 1'b1;
                        dir_d   = (tgt_clamped > phase_q);
                        cnt_d   = '0;
                    end
                end
                S_STEP: begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q + CNT_ONE;
                end
                S_WAIT: begin
                    if (ps_done[i]) begin
                        phase_d = dir_q ? (phase_q + ONE_S) : (phase_q - ONE_S);
                        if (phase_d != tgt_d) begin
                            state_d = S_STEP;
                            en_d    = 1'b1;
                            dir_d   = (tgt_d > phase_d);
                            cnt_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        // Abandon the step: phase stays put, flag stays until reconfigured
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // A configure always forces one low cycle, even when no step is needed
            cfg_d = (state_d == S_IDLE) && (phase_d == tgt_d) && !err_d && !configure[i];
        end

        // State and output registers
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= S_IDLE;
                phase_q <= '0;
                tgt_q   <= '0;
                cnt_q   <= '0;
                en_q    <= 1'b0;
                dir_q   <= 1'b0;
                err_q   <= 1'b0;
                cfg_q   <= 1'b1;
            end else begin
                state_q <= state_d;
                phase_q <= phase_d;
                tgt_q   <= tgt_d;
                cnt_q   <= cnt_d;
                en_q    <= en_d;
                dir_q   <= dir_d;
                err_q   <= err_d;
                cfg_q   <= cfg_d;
            end
        end

        assign configured[i]                             = cfg_q;
        assign err[i]                                    = err_q;
        assign ps_en[i]                                  = en_q;
        assign ps_inc_dec[i]                             = dir_q;
        assign phase[i*PHASE_WIDTH +: PHASE_WIDTH]       = phase_q;
    end

endmodule

// File: tb/tb_mmcm_phaseshift_mc.sv
// Directed self-checking bench for mmcm_phaseshift_mc with a 2-channel
// MMCM PSDONE responder model.
module tb_mmcm_phaseshift_mc;

    localparam int unsigned N_CH        = 2;
    localparam int unsigned PW          = 32;
    localparam int unsigned TIMEOUT_CYC = 1023;
    localparam int          DELAY       = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_CH*PW-1:0]   target;
    logic [N_CH-1:0]      configure;
    logic [N_CH-1:0]      configured;
    logic [N_CH-1:0]      err;
    logic [N_CH*PW-1:0]   phase;
    logic [N_CH-1:0]      ps_en;
    logic [N_CH-1:0]      ps_inc_dec;
    logic [N_CH-1:0]      ps_done = '0;

    int errors = 0;
    int checks = 0;

    int   inc_cnt [N_CH];
    int   dec_cnt [N_CH];
    int   overlap [N_CH];
    int   dir_bad [N_CH];
    int   cd      [N_CH];
    logic dir_rec [N_CH];
    logic resp_en [N_CH];

    always #5 clk = ~clk;

    mmcm_phaseshift_mc #(
        .N_CH        (N_CH),
        .PHASE_WIDTH (PW),
        .MAX_PHASE   (280),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .target     (target),
        .configure  (configure),
        .configured (configured),
        .err        (err),
        .phase      (phase),
        .ps_en      (ps_en),
        .ps_inc_dec (ps_inc_dec),
        .ps_done    (ps_done)
    );

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            inc_cnt[i] = 0; dec_cnt[i] = 0; overlap[i] = 0; dir_bad[i] = 0;
            cd[i] = 0; dir_rec[i] = 1'b0;
        end
    end

    // MMCM model: PSDONE DELAY cycles after each PSEN; counts pulses and protocol slips
    always @(negedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            ps_done[i] = 1'b0;
            if (rst === 1'b1) begin
                cd[i] = 0;
            end else begin
                if (cd[i] > 0) begin
                    cd[i] = cd[i] - 1;
                    if (cd[i] == 0) begin
                        ps_done[i] = 1'b1;
                        if (ps_inc_dec[i] !== dir_rec[i]) dir_bad[i] = dir_bad[i] + 1;
                    end
                end
                if (ps_en[i] === 1'b1) begin
                    if (cd[i] > 0) overlap[i] = overlap[i] + 1;
                    if (ps_inc_dec[i] === 1'b1) inc_cnt[i] = inc_cnt[i] + 1;
                    else                        dec_cnt[i] = dec_cnt[i] + 1;
                    dir_rec[i] = ps_inc_dec[i];
                    if (resp_en[i]) cd[i] = DELAY;
                end
            end
        end
    end

    function automatic logic signed [31:0] ph(input int ch);
        return $signed(phase[ch*PW +: PW]);
    endfunction

    // Caller is at a negedge; returns at the negedge after the sampling edge
    task automatic cfg(input logic [N_CH-1:0] mask, input int v0, input int v1);
        target    = {32'(v1), 32'(v0)};
        configure = mask;
        @(negedge clk);
        configure = '0;
    endtask

    task automatic wait_cfg(input int ch, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (configured[ch] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        configure = 2'b01;
        target    = {32'd0, 32'd7};
        resp_en[0] = 1'b1;
        resp_en[1] = 1'b1;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        configure = '0;
        checks++; if (ph(0) !== 0) begin errors++; $display("FAIL reset_phase0: got %0d expected 0", ph(0)); end
        checks++; if (ph(1) !== 0) begin errors++; $display("FAIL reset_phase1: got %0d expected 0", ph(1)); end
        checks++; if (configured !== 2'b11) begin errors++; $display("FAIL reset_configured: got %b expected 11", configured); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
        checks++; if (ps_en !== 2'b00) begin errors++; $display("FAIL reset_ps_en: got %b expected 00", ps_en); end
        checks++; if (ps_inc_dec !== 2'b00) begin errors++; $display("FAIL reset_ps_inc_dec: got %b expected 00", ps_inc_dec); end
        repeat (4) @(negedge clk);
        checks++; if (ph(0) !== 0) begin errors++; $display("FAIL cfg_during_rst_phase: got %0d expected 0", ph(0)); end
        checks++; if (configured !== 2'b11) begin errors++; $display("FAIL cfg_during_rst_configured: got %b expected 11", configured); end
        checks++; if (inc_cnt[0] + dec_cnt[0] !== 0) begin errors++; $display("FAIL cfg_during_rst_pulses: got %0d expected 0", inc_cnt[0] + dec_cnt[0]); end
    endtask

    task automatic test_basic_move();
        int i0, d0, p1;
        bit ok;
        i0 = inc_cnt[0]; d0 = dec_cnt[0]; p1 = inc_cnt[1] + dec_cnt[1];
        cfg(2'b01, 100, 0);
        checks++; if (configured[0] !== 1'b0) begin errors++; $display("FAIL basic_cfg_low: got %b expected 0", configured[0]); end
        checks++; if (ps_en[0] !== 1'b1 || ps_inc_dec[0] !== 1'b1) begin errors++; $display("FAIL basic_first_pulse: got en=%b dir=%b expected en=1 dir=1", ps_en[0], ps_inc_dec[0]); end
        wait_cfg(0, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got configured=%b expected 1 within budget", configured[0]); end
        checks++; if (inc_cnt[0] - i0 !== 100) begin errors++; $display("FAIL basic_inc_pulses: got %0d expected 100", inc_cnt[0] - i0); end
        checks++; if (dec_cnt[0] - d0 !== 0) begin errors++; $display("FAIL basic_dec_pulses: got %0d expected 0", dec_cnt[0] - d0); end
        checks++; if (ph(0) !== 100) begin errors++; $display("FAIL basic_phase0: got %0d expected 100", ph(0)); end
        checks++; if (ph(1) !== 0) begin errors++; $display("FAIL basic_phase1: got %0d expected 0", ph(1)); end
        checks++; if (inc_cnt[1] + dec_cnt[1] - p1 !== 0) begin errors++; $display("FAIL basic_ch1_pulses: got %0d expected 0", inc_cnt[1] + dec_cnt[1] - p1); end
    endtask

    task automatic test_clamp();
        int i0, d0;
        bit ok;
        i0 = inc_cnt[0];
        cfg(2'b01, 1000, 0);
        wait_cfg(0, 5000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clamp_hi_timeout: got configured=%b expected 1 within budget", configured[0]); end
        checks++; if (ph(0) !== 280) begin errors++; $display("FAIL clamp_hi_phase: got %0d expected 280", ph(0)); end
        checks++; if (inc_cnt[0] - i0 !== 180) begin errors++; $display("FAIL clamp_hi_pulses: got %0d expected 180", inc_cnt[0] - i0); end
        i0 = inc_cnt[0]; d0 = dec_cnt[0];
        cfg(2'b01, -1000, 0);
        wait_cfg(0, 8000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clamp_lo_timeout: got configured=%b expected 1 within budget", configured[0]); end
        checks++; if (ph(0) !== -280) begin errors++; $display("FAIL clamp_lo_phase: got %0d expected -280", ph(0)); end
        checks++; if (dec_cnt[0] - d0 !== 560) begin errors++; $display("FAIL clamp_lo_dec_pulses: got %0d expected 560", dec_cnt[0] - d0); end
        checks++; if (inc_cnt[0] - i0 !== 0) begin errors++; $display("FAIL clamp_lo_inc_pulses: got %0d expected 0", inc_cnt[0] - i0); end
    endtask

    task automatic test_retarget();
        int i0, d0;
        bit ok;
        bit hit;
        cfg(2'b01, 0, 0);
        wait_cfg(0, 5000, ok);
        checks++; if (ph(0) !== 0) begin errors++; $display("FAIL retarget_home: got %0d expected 0", ph(0)); end
        i0 = inc_cnt[0]; d0 = dec_cnt[0];
        cfg(2'b01, 50, 0);
        hit = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (ph(0) === 20) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!hit) begin errors++; $display("FAIL retarget_reach20: got %0d expected 20 within budget", ph(0)); end
        cfg(2'b01, 10, 0);
        wait_cfg(0, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL retarget_timeout: got configured=%b expected 1 within budget", configured[0]); end
        checks++; if (ph(0) !== 10) begin errors++; $display("FAIL retarget_phase: got %0d expected 10", ph(0)); end
        checks++; if (inc_cnt[0] - i0 !== 21) begin errors++; $display("FAIL retarget_inc_pulses: got %0d expected 21", inc_cnt[0] - i0); end
        checks++; if (dec_cnt[0] - d0 !== 11) begin errors++; $display("FAIL retarget_dec_pulses: got %0d expected 11", dec_cnt[0] - d0); end
        checks++; if (overlap[0] !== 0) begin errors++; $display("FAIL retarget_overlap: got %0d expected 0", overlap[0]); end
    endtask

    task automatic test_timeout();
        int i1;
        int lat;
        bit ok;
        resp_en[1] = 1'b0;
        i1 = inc_cnt[1];
        cfg(2'b10, 0, 5);
        checks++; if (ps_en[1] !== 1'b1) begin errors++; $display("FAIL timeout_first_pulse: got %b expected 1", ps_en[1]); end
        lat = -1;
        for (int k = 1; k < int'(TIMEOUT_CYC) + 50; k++) begin
            @(negedge clk);
            if (err[1] === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat !== int'(TIMEOUT_CYC)) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", lat, TIMEOUT_CYC); end
        checks++; if (ph(1) !== 0) begin errors++; $display("FAIL timeout_phase1: got %0d expected 0", ph(1)); end
        checks++; if (configured[1] !== 1'b0) begin errors++; $display("FAIL timeout_configured: got %b expected 0", configured[1]); end
        repeat (5) @(negedge clk);
        checks++; if (err[1] !== 1'b1 || configured[1] !== 1'b0) begin errors++; $display("FAIL timeout_sticky: got err=%b cfg=%b expected err=1 cfg=0", err[1], configured[1]); end
        checks++; if (inc_cnt[1] - i1 !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", inc_cnt[1] - i1); end
        resp_en[1] = 1'b1;
        cfg(2'b10, 0, 5);
        checks++; if (err[1] !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: got %b expected 0", err[1]); end
        wait_cfg(1, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_recover_wait: got configured=%b expected 1 within budget", configured[1]); end
        checks++; if (ph(1) !== 5) begin errors++; $display("FAIL timeout_recover_phase: got %0d expected 5", ph(1)); end
    endtask

    task automatic test_back_to_back();
        int i0, d1;
        bit ok;
        i0 = inc_cnt[0]; d1 = dec_cnt[1];
        cfg(2'b11, 30, -30);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (configured === 2'b11) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL dual_timeout: got configured=%b expected 11 within budget", configured); end
        checks++; if (ph(0) !== 30) begin errors++; $display("FAIL dual_phase0: got %0d expected 30", ph(0)); end
        checks++; if (ph(1) !== -30) begin errors++; $display("FAIL dual_phase1: got %0d expected -30", ph(1)); end
        checks++; if (inc_cnt[0] - i0 !== 20) begin errors++; $display("FAIL dual_ch0_pulses: got %0d expected 20", inc_cnt[0] - i0); end
        checks++; if (dec_cnt[1] - d1 !== 35) begin errors++; $display("FAIL dual_ch1_pulses: got %0d expected 35", dec_cnt[1] - d1); end
        checks++; if (overlap[1] !== 0) begin errors++; $display("FAIL dual_overlap: got %0d expected 0", overlap[1]); end
        i0 = inc_cnt[0] + dec_cnt[0];
        cfg(2'b01, 30, 0);
        checks++; if (configured[0] !== 1'b0 || ps_en[0] !== 1'b0) begin errors++; $display("FAIL same_t1: got cfg=%b en=%b expected cfg=0 en=0", configured[0], ps_en[0]); end
        @(negedge clk);
        checks++; if (configured[0] !== 1'b1 || ps_en[0] !== 1'b0) begin errors++; $display("FAIL same_t2: got cfg=%b en=%b expected cfg=1 en=0", configured[0], ps_en[0]); end
        repeat (3) @(negedge clk);
        checks++; if (inc_cnt[0] + dec_cnt[0] - i0 !== 0) begin errors++; $display("FAIL same_pulses: got %0d expected 0", inc_cnt[0] + dec_cnt[0] - i0); end
    endtask

    task automatic test_reset_midstep();
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cfg(2'b01, 50, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (phase !== '0) begin errors++; $display("FAIL midrst_phase: got %h expected 0", phase); end
        checks++; if (configured !== 2'b11) begin errors++; $display("FAIL midrst_configured: got %b expected 11", configured); end
        checks++; if (err !== 2'b00 || ps_en !== 2'b00 || ps_inc_dec !== 2'b00) begin errors++; $display("FAIL midrst_ctrl: got err=%b en=%b dir=%b expected 00 00 00", err, ps_en, ps_inc_dec); end
        rst = 1'b0;
        @(negedge clk);
        cfg(2'b01, 10, 0);
        wait_cfg(0, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_recover_wait: got configured=%b expected 1 within budget", configured[0]); end
        checks++; if (ph(0) !== 10) begin errors++; $display("FAIL midrst_recover_phase: got %0d expected 10", ph(0)); end
        checks++; if (dir_bad[0] + dir_bad[1] !== 0) begin errors++; $display("FAIL dir_stability: got %0d expected 0", dir_bad[0] + dir_bad[1]); end
    endtask

    initial begin
        rst       = 1'b1;
        configure = '0;
        target    = '0;
        @(negedge clk);
        test_reset();
        test_basic_move();
        test_clamp();
        test_retarget();
        test_timeout();
        test_back_to_back();
        test_reset_midstep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmcm_phaseshift_mc.md
MMCM_PHASESHIFT_MC -- requirements
Module: mmcm_phaseshift_mc

Interface
REQ-001 Parameter N_CH, default 2: number of independent MMCM phase-shift channels, range 1..8.
REQ-002 Parameter PHASE_WIDTH, default 32: width of each signed target and phase word.
REQ-003 Parameter MAX_PHASE, default 280: symmetric clamp limit in steps (aliasing boundary, 50% of cycle).
REQ-004 Parameter TIMEOUT_CYC, default 1023: maximum cycles from ps_en to ps_done before a step is declared failed.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous active-high reset; the external MMCMs are reset by the same signal.
REQ-008 target  input  N_CH*PHASE_WIDTH  packed signed target per channel; channel i occupies bits [i*PHASE_WIDTH +: PHASE_WIDTH].
REQ-009 configure  input  N_CH  one-cycle request per channel to latch the new target.
REQ-010 configured  output  N_CH  level, high when the channel is idle and phase equals latched target.
REQ-011 err  output  N_CH  sticky ps_done timeout flag per channel.
REQ-012 phase  output  N_CH*PHASE_WIDTH  signed current applied phase per channel.
REQ-013 ps_en  output  N_CH  one-cycle MMCM PSEN pulse per channel.
REQ-014 ps_inc_dec  output  N_CH  MMCM PSINCDEC per channel; 1 = increment.
REQ-015 ps_done  input  N_CH  MMCM PSDONE per channel, one-cycle pulse.

Function
REQ-016 Each channel SHALL run an independent FSM: IDLE, STEP, WAIT; channels share no state.
REQ-017 configure[i] sampled at edge t SHALL latch target clamped to [-MAX_PHASE, +MAX_PHASE], clear err[i], and drive configured[i] low from t+1.
REQ-018 If the clamped target equals phase[i], the FSM SHALL remain IDLE and configured[i] SHALL return high at t+2, with no ps_en.
REQ-019 Otherwise the FSM SHALL enter STEP: ps_en[i] high for exactly one cycle starting t+1, then WAIT.
REQ-020 ps_inc_dec[i] SHALL be 1 when target > phase, 0 when target < phase, valid with ps_en and held stable until the matching ps_done.
REQ-021 In WAIT, ps_done[i] SHALL update phase[i] by +1 or -1 per ps_inc_dec[i] on that edge.
REQ-022 After ps_done, if phase equals target the FSM SHALL go IDLE and assert configured[i] the next cycle; else it SHALL issue the next ps_en[i] on the cycle after ps_done.
REQ-023 ps_done[i] while not in WAIT SHALL be ignored (phase unchanged).
REQ-024 configure[i] during STEP or WAIT SHALL latch the new clamped target immediately; the in-flight step SHALL complete, direction for subsequent steps SHALL be recomputed against the new target, never issuing ps_en while a step is outstanding.
REQ-025 If the retarget equals phase after the in-flight step completes, the channel SHALL go IDLE without further steps.
REQ-026 If ps_done[i] is not received within TIMEOUT_CYC cycles of ps_en[i], err[i] SHALL set, the FSM SHALL return to IDLE, phase[i] SHALL be unchanged, configured[i] SHALL stay low until the next configure.
REQ-027 Comparisons and clamping SHALL be signed at PHASE_WIDTH; phase SHALL never leave [-MAX_PHASE, +MAX_PHASE].
REQ-028 Simultaneous configure on multiple channels SHALL be accepted on the same edge with no ordering dependency.

Reset
REQ-029 rst SHALL force every channel to IDLE in one cycle regardless of state, including mid-step.
REQ-030 Reset values: phase = 0, latched target = 0, configured = all ones, err = 0, ps_en = 0, ps_inc_dec = 0, timeout counters = 0.
REQ-031 configure asserted with rst SHALL be ignored.

Verification
REQ-032 Ch0 from reset, target 100, ps_done 12 cycles after each ps_en -> 100 pulses all with ps_inc_dec=1; phase0=100; configured[0] high; ch1 untouched, phase1=0.
REQ-033 Ch0 target 1000 then -1000 -> clamps: phase0 ends 280, then -280; exactly 560 decrement pulses in the second move.
REQ-034 Ch0 stepping 0 -> 50; at phase0=20 configure target 10 -> in-flight step completes to 21, then 11 decrements; phase0=10, never two outstanding ps_en.
REQ-035 Ch1 target 5 with ps_done held low -> err[1] high TIMEOUT_CYC cycles after ps_en, phase1=0, configured[1] low; next configure target 5 with normal ps_done clears err[1] and reaches 5.
REQ-036 Both channels configured same edge, ch0 target 30, ch1 target -30 -> both complete independently, phases 30 and -30; then same target 30 on ch0 -> no ps_en, configured[0] low one cycle, high at t+2.
REQ-037 rst asserted 3 cycles after first ps_en of a 0 -> 50 move -> all outputs at reset values next cycle; subsequent target 10 reaches phase0=10.
